// File: rtl/trap_pkg.sv
// +----------------------------------------------------------------------------+
// | trap_pkg: FSM encoding, mcause values and mtvec mode constants for         |
// |           trap_ctrl.                                                       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTER    = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_EXIT     = 2'd3
  } trap_state_e;

  localparam logic [31:0] CAUSE_FETCH_MISALIGN = 32'h0000_0000;
  localparam logic [31:0] CAUSE_ILLEGAL        = 32'h0000_0002;
  localparam logic [31:0] CAUSE_BREAKPOINT     = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL_M        = 32'h0000_000B;
  localparam logic [31:0] CAUSE_IRQ_EXT        = 32'h8000_000B;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  localparam logic [4:0] IRQ_EXT_VEC_IDX = 5'd11;

  // Vectored handler address: base + 4*idx, wrapping modulo 2^32.
  function automatic logic [31:0] vec_target(input logic [31:0] base, input logic [4:0] idx);
    return base + {25'd0, idx, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_irq_sync.sv
// +----------------------------------------------------------------------------+
// | trap_irq_sync: two-flop synchronizer for the external interrupt level.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module trap_irq_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// +----------------------------------------------------------------------------+
// | trap_ctrl: trap entry / MRET return sequencer for the machine-mode CSR     |
// |            file. External interrupt support under TRAP_CTRL_IRQ_EN.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            exc_fetch_misalign,
  input  logic            exc_illegal,
  input  logic            exc_ebreak,
  input  logic            exc_ecall,
  input  logic            is_mret,
`ifdef TRAP_CTRL_IRQ_EN
  input  logic            irq_ext,
`endif
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            stall,
  output logic            trap_enter,
  output logic            trap_exit,
  output logic [XLEN-1:0] exception_code,
  output logic [XLEN-1:0] trap_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  trap_state_e     r_state;
  trap_state_e     w_next;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_pc;
  logic            r_irq;

  logic            w_irq_pend;
  logic            w_exc;
  logic            w_trap;
  logic            w_detect;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_handler;

`ifdef TRAP_CTRL_IRQ_EN
  logic w_irq_sync;

  trap_irq_sync u_irq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (irq_ext),
    .o_sync  (w_irq_sync)
  );

  assign w_irq_pend = w_irq_sync & mstatus_mie;
`else
  logic w_unused_cfg;

  assign w_irq_pend   = 1'b0;
  assign w_unused_cfg = mstatus_mie ^ r_irq ^ (^mtvec[1:0]);
`endif

  assign w_exc    = exc_fetch_misalign | exc_illegal | exc_ebreak | exc_ecall;
  assign w_trap   = w_irq_pend | w_exc;
  // Gated by reset so outputs read 0 while reset is held, even combinationally.
  assign w_detect = reset_n & instr_valid & (w_trap | is_mret);

  always_comb begin
    w_cause = XLEN'(CAUSE_ECALL_M);
    if (w_irq_pend)              w_cause = XLEN'(CAUSE_IRQ_EXT);
    else if (exc_fetch_misalign) w_cause = XLEN'(CAUSE_FETCH_MISALIGN);
    else if (exc_illegal)        w_cause = XLEN'(CAUSE_ILLEGAL);
    else if (exc_ebreak)         w_cause = XLEN'(CAUSE_BREAKPOINT);
  end

  assign w_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_CTRL_IRQ_EN
  assign w_handler = (r_irq && (mtvec[1:0] == MTVEC_MODE_VECTORED))
                   ? XLEN'(vec_target(w_base, IRQ_EXT_VEC_IDX)) : w_base;
`else
  assign w_handler = w_base;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cause <= '0;
      r_pc    <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && w_detect && w_trap) begin
        r_cause <= w_cause;
        r_pc    <= pc;
        r_irq   <= w_irq_pend;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    stall          = 1'b0;
    trap_enter     = 1'b0;
    trap_exit      = 1'b0;
    exception_code = '0;
    trap_pc        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_detect) begin
          stall  = 1'b1;
          w_next = w_trap ? ST_ENTER : ST_EXIT;
        end
      end
      ST_ENTER: begin
        stall          = 1'b1;
        trap_enter     = 1'b1;
        exception_code = r_cause;
        trap_pc        = r_pc;
        w_next         = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = w_handler;
        w_next         = ST_IDLE;
      end
      ST_EXIT: begin
        stall          = 1'b1;
        trap_exit      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = mepc;
        w_next         = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/trap_ctrl.md
# trap_ctrl

Sequencer for trap entry and MRET return around the machine-mode CSR file of the single-cycle RV32IM core. Prioritises synchronous exceptions and an optional external interrupt, stalls the core, and pulses the CSR file's `trap_enter`/`trap_exit` with the correct cause and PC. It then issues a one-cycle PC redirect to the handler or to `mepc`. Sits between decode/execute and the CSR file; owns no architectural state beyond its FSM and latched trap info.

## Interface
- `XLEN`, 32: datapath width.
- `clk` in 1: core clock.
- `reset_n` in 1: **asynchronous, active-low** reset; single clock domain (`clk`).
- `instr_valid` in 1: the current instruction executes this cycle.
- `pc` in XLEN: PC of the current instruction.
- `exc_fetch_misalign`, `exc_illegal`, `exc_ebreak`, `exc_ecall` in 1 each: exception flags from decode.
- `is_mret` in 1: the current instruction is MRET.
- `irq_ext` in 1: asynchronous external interrupt, level. Present only with `TRAP_CTRL_IRQ_EN`.
- `mstatus_mie` in 1: `mstatus[3]` from the CSR file.
- `mtvec` in XLEN: trap vector from the CSR file.
- `mepc` in XLEN: return address from the CSR file.
- `stall` out 1: freezes PC and blocks register-file writes.
- `trap_enter` out 1: one-cycle pulse to the CSR file.
- `trap_exit` out 1: one-cycle pulse to the CSR file.
- `exception_code` out XLEN: cause written to `mcause`.
- `trap_pc` out XLEN: value written to `mepc`. Drives the CSR file's `current_pc`.
- `redirect_valid` out 1: PC is loaded with `redirect_pc` this cycle.
- `redirect_pc` out XLEN: next PC.

## Operation
- FSM states: IDLE, ENTER, REDIRECT, EXIT.
- IDLE:
  - `detect` = `instr_valid` and (any exception, or pending IRQ, or `is_mret`).
  - On `detect`: latch cause and `pc`, assert `stall` combinationally in the same cycle, and go to ENTER (trap) or EXIT (MRET).
- Priority, highest first:
  - IRQ (`irq_sync & mstatus_mie`): cause 0x8000000B.
  - fetch misaligned: cause 0.
  - illegal: cause 2.
  - ebreak: cause 3.
  - ecall: cause 11.
  - MRET.
  - An exception always suppresses MRET.
  - An IRQ preempts the instruction; that instruction is not executed, and `trap_pc` = its `pc`.
- ENTER: `trap_enter`=1, `stall`=1. `exception_code` and `trap_pc` are driven from latches. Next state: REDIRECT.
- REDIRECT: `redirect_valid`=1, `stall`=1. Next state: IDLE.
  - `redirect_pc` = {`mtvec[31:2]`,2'b00}.
  - Exception: `mtvec[1:0]`=01 (vectored) has no effect.
  - IRQ with `mtvec[1:0]`=01: `redirect_pc` = base + 4×11, modulo 2^32.
- EXIT: `trap_exit`=1, `redirect_valid`=1, `redirect_pc`=`mepc`, `stall`=1. Next state: IDLE.
- Events outside IDLE are ignored and not queued. A still-asserted IRQ is re-evaluated in IDLE.
- `instr_valid`=0 in IDLE: no action, even if IRQ is pending.
- Outputs idle value 0 whenever not asserted by the active state.

## Timing
- Trap detected in cycle N:
  - `stall` in N, N+1, N+2.
  - `trap_enter` in N+1; the CSR file updates `mepc`/`mcause`/`mstatus` at the N+1→N+2 edge.
  - Redirect in N+2.
  - Handler's first instruction in N+3.
- MRET detected in N: `trap_exit` and redirect in N+1; return target executes in N+2.
- IRQ latency from `irq_ext` rising: 2 sync cycles plus the next IDLE cycle with `instr_valid`.
- Reset (any time, including mid-sequence): state IDLE, all outputs 0, latches cleared, synchronizer cleared. A partial sequence is abandoned without a pulse.

## Configuration
- `TRAP_CTRL_IRQ_EN` defined: `irq_ext` port, 2-flop synchronizer, and IRQ priority/vectoring are present.
- Undefined: no `irq_ext` port; only exceptions and MRET are handled, and `mtvec` mode bits are ignored.

## Structure
- Package `trap_pkg`: FSM state encoding, cause constants (CAUSE_FETCH_MISALIGN=0, CAUSE_ILLEGAL=2, CAUSE_BREAKPOINT=3, CAUSE_ECALL_M=11, CAUSE_IRQ_EXT=0x8000000B), and vector mode constants.
- One sub-module, `trap_irq_sync`: 2-flop synchronizer, reset to 0 by `reset_n`. Instantiated only under `TRAP_CTRL_IRQ_EN`.

## Test plan
- ecall at `pc`=0x100, `mtvec`=0x200 → `trap_enter` in N+1 with code 11 and `trap_pc`=0x100; redirect to 0x200 in N+2; `stall` high for 3 cycles.
- illegal+ecall together at 0x104 → code 2 only.
- MRET with `mepc`=0x104 → `trap_exit` and redirect to 0x104 in N+1; no `trap_enter`.
- ecall+MRET together → trap taken with code 11; no `trap_exit`.
- IRQ (macro on), `mie`=1, `mtvec`=0x201, `pc`=0x300 → code 0x8000000B, `trap_pc`=0x300, redirect 0x22C. With `mie`=0 → no trap.
- `reset_n` low during ENTER → outputs 0 immediately; after release, IDLE with no pending pulse.
